// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad encoder.
package keypad_pkg;

  localparam int unsigned KEY_W  = 5;
  localparam int unsigned ROW_W  = 2;
  localparam int unsigned COL_W  = 2;
  localparam int unsigned DEB_W  = 4;
  localparam int unsigned DATA_W = 32;

  // Same value the seven-segment driver treats as blank
  localparam logic [KEY_W-1:0] NO_KEY = 5'h10;

  localparam logic [1:0] ADDR_KEY    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  typedef struct packed {
    logic held;
    logic new_key;
  } status_t;

  // Index of the lowest-numbered low (pressed) column; 0 when none is low
  function automatic logic [COL_W-1:0] lowest_low(input logic [3:0] c);
    lowest_low = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!c[i]) lowest_low = COL_W'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Scan-rate prescaler: one-cycle tick every SCAN_DIV clocks, on the terminal count.
module keypad_scan_tick #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM     = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_TERM = CNT_W'(SCAN_DIV - 2);

  logic [CNT_W-1:0] cnt;

  // tick is registered one count early so it is high exactly while cnt == TERM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == TERM) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == PRE_TERM);
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner/debouncer with an Avalon-MM register slave.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        chipselect,
  output logic [31:0] readdata,
  output logic [3:0]  rows,
  input  logic [3:0]  cols
);

  localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_SCANS);

  logic [3:0]       sync1, sync2;
  logic             tick;
  state_e           state, state_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic [DEB_W-1:0] deb_cnt, deb_nxt;
  logic [KEY_W-1:0] key, key_nxt;
  logic             new_key;
  logic             set_new;
  logic             any_low;
  logic [COL_W-1:0] low_col;
  logic             rd_en;
  logic             clr_new;
  status_t          status;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  keypad_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Column synchronizer; idle level is all-high (pulled up)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= cols;
      sync2 <= sync1;
    end
  end

  assign any_low = ~&sync2;
  assign low_col = lowest_low(sync2);

  // State register and scan/debounce datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_SCAN;
      row     <= '0;
      col     <= '0;
      deb_cnt <= '0;
      key     <= NO_KEY;
      rows    <= 4'b1110;
    end else begin
      state   <= state_nxt;
      row     <= row_nxt;
      col     <= col_nxt;
      deb_cnt <= deb_nxt;
      key     <= key_nxt;
      rows    <= ~(4'b0001 << row_nxt);
    end
  end

  // Next-state logic; everything moves only on a scan tick
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    deb_nxt   = deb_cnt;
    key_nxt   = key;
    set_new   = 1'b0;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (any_low) begin
            col_nxt   = low_col;
            deb_nxt   = DEB_W'(1);
            state_nxt = ST_DEBOUNCE;
          end else begin
            row_nxt = row + ROW_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (any_low && (low_col == col)) begin
            deb_nxt = deb_cnt + DEB_W'(1);
            if (deb_nxt == DEB_DONE) begin
              key_nxt   = {1'b0, row, col};
              set_new   = 1'b1;
              state_nxt = ST_HELD;
            end
          end else begin
            row_nxt   = row + ROW_W'(1);
            state_nxt = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (!any_low) begin
            deb_nxt   = DEB_W'(1);
            state_nxt = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (any_low) begin
            state_nxt = ST_HELD;
          end else begin
            deb_nxt = deb_cnt + DEB_W'(1);
            if (deb_nxt == DEB_DONE) begin
              row_nxt   = row + ROW_W'(1);
              state_nxt = ST_SCAN;
            end
          end
        end
        default: state_nxt = ST_SCAN;
      endcase
    end
  end

  assign rd_en   = chipselect && read;
  assign clr_new = (rd_en && (address == ADDR_KEY)) ||
                   (chipselect && write && (address == ADDR_STATUS) && writedata[0]);
  assign unused_wdata = ^writedata[31:1];

  // A latch event on the same edge as a clear keeps the flag set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     new_key <= 1'b0;
    else if (set_new) new_key <= 1'b1;
    else if (clr_new) new_key <= 1'b0;
  end

  assign status.held    = (state == ST_HELD) || (state == ST_RELEASE);
  assign status.new_key = new_key;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_KEY:    rd_mux = {27'b0, key};
      ADDR_STATUS: rd_mux = {30'b0, status};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboard bench for keypad_encoder: a keypad switch model drives cols from rows.
module tb_keypad_encoder;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 3;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b1;
  logic [1:0]  address    = '0;
  logic        read       = 1'b0;
  logic        write      = 1'b0;
  logic [31:0] writedata  = '0;
  logic        chipselect = 1'b0;
  logic [31:0] readdata;
  logic [3:0]  rows;
  logic [3:0]  cols;

  logic [15:0] pressed = '0;   // bit r*4+c = switch at row r, column c closed
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = '0;
  logic [4:0]  m_key = 5'h10;
  logic        m_new = 1'b0;

  always #5 clk = ~clk;

  keypad_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .chipselect (chipselect),
    .readdata   (readdata),
    .rows       (rows),
    .cols       (cols)
  );

  // A closed switch pulls its column low only while its row is driven low
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !rows[r]) cols[c] = 1'b0;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted read must present the queued expectation one cycle later
  initial forever begin
    @(posedge clk);
    if (reset_n && chipselect && read) begin
      #1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL readdata: got 0x%0h with no expected value queued", readdata);
      end else begin
        check("readdata", readdata, exp_q.pop_front());
      end
    end
  end

  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    last_rd    = e;
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    if (a == 2'd1 && d[0]) m_new = 1'b0;
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic wait_cyc(input int k);
    int guard = 0;
    while (cyc < k && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("cycle_align", 32'(cyc), 32'(k));
  endtask

  // Reset with a switch pattern applied while in reset; cycle 1 is the first edge after release
  task automatic do_reset(input logic [15:0] mask);
    reset_n = 1'b0;
    #1;
    check("reset_rows", {28'b0, rows}, 32'h0000_000E);
    check("reset_readdata", readdata, 32'h0);
    pressed = mask;
    m_key   = 5'h10;
    m_new   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic press_long(input int r, input logic [3:0] cm);
    int lc = 0;
    int nops;
    pressed = 16'(cm) << (4 * r);
    repeat (60) @(posedge clk);
    #1;
    for (int c = 3; c >= 0; c--) if (cm[c]) lc = c;
    m_key = 5'(r * 4 + lc);
    m_new = 1'b1;
    nops = $urandom_range(0, 3);
    for (int i = 0; i < nops; i++) begin
      if ($urandom_range(0, 2) == 0) rd(2'(2 + $urandom_range(0, 1)), 32'h0);
      else                           wr(2'($urandom_range(0, 3)), $urandom);
    end
    rd(2'd1, {30'b0, 1'b1, m_new});
    rd(2'd0, {27'b0, m_key});
    m_new = 1'b0;
    rd(2'd1, 32'h2);
    pressed = '0;
    repeat (40) @(posedge clk);
    #1;
    rd(2'd1, 32'h0);
    rd(2'd0, {27'b0, m_key});
  endtask

  // A closure of at most one scan period can be seen by at most one tick
  task automatic glitch();
    int          r  = $urandom_range(0, 3);
    logic [3:0]  cm = 4'($urandom_range(1, 15));
    pressed = 16'(cm) << (4 * r);
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1;
    pressed = '0;
    repeat (40) @(posedge clk);
    #1;
    rd(2'd1, {30'b0, 1'b0, m_new});
    rd(2'd0, {27'b0, m_key});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    // Reset values and idle register map
    do_reset('0);
    rd(2'd0, 32'h10);
    rd(2'd1, 32'h0);
    rd(2'd2, 32'h0);
    rd(2'd3, 32'h0);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd2, 32'h1);
    rd(2'd0, 32'h10);

    // Row2/col1 for only two ticks: rejected, scanning resumes on row 3
    do_reset(16'(1) << 9);
    wait_cyc(17);
    pressed = '0;
    wait_cyc(21);
    check("resume_row3", {28'b0, rows}, 32'h0000_0007);
    repeat (30) @(posedge clk);
    #1;
    rd(2'd1, 32'h0);
    rd(2'd0, 32'h10);

    // Row2/col1 held: latched on the third tick; write-clear on that edge loses
    do_reset(16'(1) << 9);
    wait_cyc(17);
    rd(2'd1, 32'h0);
    wait_cyc(19);
    wr(2'd1, 32'h1);
    rd(2'd1, 32'h3);
    rd(2'd0, 32'h9);
    rd(2'd1, 32'h2);
    m_key   = 5'h9;
    pressed = '0;
    repeat (40) @(posedge clk);
    #1;
    rd(2'd1, 32'h0);
    rd(2'd0, 32'h9);

    // Two low columns on row 1: lowest wins
    press_long(1, 4'b1001);

    // Reset mid-debounce discards the pending key
    do_reset(16'(1) << 6);
    rd(2'd0, 32'h10);
    wait_cyc(10);
    do_reset('0);
    repeat (40) @(posedge clk);
    #1;
    rd(2'd1, 32'h0);
    rd(2'd0, 32'h10);
    press_long(1, 4'b0100);

    // Random presses and glitches against the switch-level expectation
    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 9) < 7) press_long($urandom_range(0, 3), 4'($urandom_range(1, 15)));
      else                          glitch();
      repeat (5) @(posedge clk);
      #1;
      check("readdata_hold", readdata, last_rd);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per scan tick (legal range ≥ 4).
REQ-002 Parameter DEBOUNCE_SCANS, default 4, consecutive stable ticks needed to accept a press or a release (legal range 2..15).
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address  input  2  Avalon-MM word address.
REQ-006 read  input  1  Avalon-MM read strobe.
REQ-007 write  input  1  Avalon-MM write strobe.
REQ-008 writedata  input  32  Avalon-MM write data.
REQ-009 chipselect  input  1  Avalon-MM slave select.
REQ-010 readdata  output  32  registered Avalon-MM read data.
REQ-011 rows  output  4  keypad row drive, active-low, exactly one bit low at all times.
REQ-012 cols  input  4  keypad column sense, externally pulled up, low = pressed.

Function
REQ-013 cols SHALL pass through a 2-flop synchronizer before use.
REQ-014 A prescaler SHALL count 0..SCAN_DIV-1 and assert a one-cycle tick at terminal count, then wrap to 0.
REQ-015 Key code SHALL be row*4+col (0x0..0xF); NO_KEY = 5'h10, matching the seven-segment blank code.
REQ-016 When several columns are low, the lowest-numbered low column SHALL be taken.
REQ-017 FSM states SHALL be SCAN, DEBOUNCE, HELD and RELEASE; all transitions SHALL occur only on tick.
REQ-018 In SCAN with all cols high, the FSM SHALL advance the row (3 wraps to 0) and update rows on that edge.
REQ-019 In SCAN with any col low, the FSM SHALL capture the candidate column, set deb_cnt=1, enter DEBOUNCE and hold the row.
REQ-020 In DEBOUNCE with the same column still lowest-low, the FSM SHALL increment deb_cnt; on reaching DEBOUNCE_SCANS it SHALL latch the code into key, set new_key and enter HELD on the same edge.
REQ-021 In DEBOUNCE with the column changed or released, the FSM SHALL return to SCAN and advance the row; key and new_key SHALL be unchanged.
REQ-022 In HELD with all cols high, the FSM SHALL enter RELEASE with deb_cnt=1; otherwise it SHALL remain in HELD. No repeat events SHALL occur.
REQ-023 In RELEASE, consecutive all-high ticks SHALL increment deb_cnt; at DEBOUNCE_SCANS the FSM SHALL enter SCAN and advance the row; any low col SHALL return it to HELD.
REQ-024 key SHALL retain the last accepted code after release.
REQ-025 Read address 0 SHALL return {27'b0, key}.
REQ-026 Read address 1 SHALL return {30'b0, held, new_key}, where held = (state is HELD or RELEASE).
REQ-027 Read addresses 2 and 3 SHALL return 0.
REQ-028 readdata SHALL be valid one cycle after chipselect&&read and SHALL hold its value until the next read.
REQ-029 A read of address 0 SHALL clear new_key.
REQ-030 A write to address 1 with writedata[0]=1 SHALL clear new_key; all other writes SHALL be ignored.
REQ-031 When a new_key set and a clear occur in the same cycle, the set SHALL win.

Reset
REQ-032 On reset_n low, immediately and regardless of state: readdata=0, rows=4'b1110, state=SCAN, row=0, key=5'h10, new_key=0, prescaler=0, deb_cnt=0, synchronizer flops=4'hF.
REQ-033 Reset asserted mid-DEBOUNCE or mid-RELEASE SHALL discard the pending event.

Structure
REQ-034 Package keypad_pkg SHALL hold the FSM state enum, register address constants and NO_KEY.
REQ-035 The prescaler SHALL be a sub-module keypad_scan_tick (parameter SCAN_DIV, output tick).

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3)
REQ-036 Reset, then read address 0 -> readdata=0 during reset, rows=4'b1110, read returns 0x10.
REQ-037 Hold row2/col1 low stable -> key=0x09 latched 2 ticks after first detection; address 1 reads 0x3; after a read of address 0, address 1 reads 0x2.
REQ-038 row2/col1 low for 2 ticks, then high -> new_key stays 0, key stays 0x10, scanning resumes at row 3.
REQ-039 row1 with col0 and col3 both low -> key=0x04.
REQ-040 Write address 1 with 0x1 on the same edge as the latch -> new_key=1.
REQ-041 reset_n pulsed low while in DEBOUNCE -> all outputs at reset values within the same cycle; no key latched afterwards until a fresh full debounce completes.
